// File: rtl/pwr_seq_pkg.sv
// pwr_seq_pkg: fault codes, sequencer state codes and fault-log entry layout
package pwr_seq_pkg;
   localparam int FLT_AUX_SEQ     = 0;
   localparam int FLT_FAN_SEQ     = 1;
   localparam int FLT_N1N2_SEQ    = 2;
   localparam int FLT_PERST_SEQ   = 3;
   localparam int FLT_AUX_RUN     = 4;
   localparam int FLT_FAN_RUN     = 5;
   localparam int FLT_N1N2_RUN    = 6;
   localparam int FLT_LARGE_LEAK  = 7;
   localparam int FLT_SMALL_LEAK  = 8;
   typedef enum logic [3:0] {
      ST_S0    = 4'h0,
      ST_HOST  = 4'h1,
      ST_DCOFF = 4'h2,
      ST_DEV   = 4'h3,
      ST_FAN   = 4'h5,
      ST_STBY  = 4'h7,
      ST_IDLE  = 4'h9,
      ST_LEAK  = 4'hE,
      ST_FAULT = 4'hF
   } seqState_t;
   typedef struct packed {
      logic [3:0]  code;
      logic [3:0]  state;
      logic [15:0] ts;
   } logEntry_t;
endpackage

// File: rtl/fault_log_fifo.sv
// fault_log_fifo: synchronous log-entry FIFO with registered pop data and drop flag
module fault_log_fifo
   import pwr_seq_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                     iClk,
   input  logic                     iRst_n,
   input  logic                     iClear,
   input  logic                     iPush,
   input  logEntry_t                iPushData,
   input  logic                     iPop,
   output logic                     oPopValid,
   output logEntry_t                oPopData,
   output logic                     oFull,
   output logic                     oEmpty,
   output logic                     oDrop,
   output logic [$clog2(DEPTH):0]   oCount
);
   localparam int AW = $clog2(DEPTH);
   logEntry_t mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic doPush, doPop;
   assign oEmpty = oCount == '0;
   assign oFull  = oCount == (AW+1)'(DEPTH);
   assign doPop  = iPop & ~oEmpty & ~iClear;
   // a pop in the same cycle frees the slot a full FIFO needs for the push
   assign doPush = iPush & ~iClear & (~oFull | doPop);
   assign oDrop  = iPush & ~iClear & oFull & ~doPop;
   always_ff @(posedge iClk or negedge iRst_n)
      if (!iRst_n) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         oCount    <= '0;
         oPopValid <= 1'b0;
         oPopData  <= '0;
      end else if (iClear) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         oCount    <= '0;
         oPopValid <= 1'b0;
      end else begin
         wrPtr     <= wrPtr + AW'(doPush);
         rdPtr     <= rdPtr + AW'(doPop);
         oCount    <= oCount + (AW+1)'(doPush) - (AW+1)'(doPop);
         oPopValid <= doPop;
         if (doPop) oPopData <= mem[rdPtr];
      end
   always_ff @(posedge iClk)
      if (doPush) mem[wrPtr] <= iPushData;
endmodule

// File: rtl/pwr_fault_log.sv
// pwr_fault_log: latches sequencer fault edges and logs timestamped events for the BMC
module pwr_fault_log
   import pwr_seq_pkg::*;
#(
   parameter int                 NUM_FLT    = 9,
   parameter int                 FIFO_DEPTH = 8,
   parameter int                 TS_W       = 16,
   parameter logic [NUM_FLT-1:0] SHDN_MASK  = NUM_FLT'((1 << FLT_LARGE_LEAK) | (1 << FLT_SMALL_LEAK))
)(
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic               iClk_1ms,
   input  logic [NUM_FLT-1:0] iFLT_N,
   input  logic [3:0]         iFSM_State,
   input  logic               iClear,
   input  logic               iRd_Req,
   output logic               oRd_Valid,
   output logic [23:0]        oRd_Data,
   output logic [3:0]         oLog_Count,
   output logic               oOverflow,
   output logic [NUM_FLT-1:0] oFlt_Sticky,
   output logic               oFirst_Valid,
   output logic [3:0]         oFirst_Code,
   output logic               oFault_Any_N,
   output logic               oShutdown_Req
);
   function automatic logic [3:0] lowIdx(input logic [NUM_FLT-1:0] v);
      lowIdx = '0;
      for (int i = NUM_FLT-1; i >= 0; i--) if (v[i]) lowIdx = 4'(i);
   endfunction
   logic [2:0] msSync;
   logic [TS_W-1:0] tsCnt;
   logic [NUM_FLT-1:0] fltPrev, pending, edges, grant;
   logic [$clog2(FIFO_DEPTH):0] cnt;
   logic msTick, drop, full, empty;
   logEntry_t pushEntry, rdEntry;
   assign msTick     = msSync[1] & ~msSync[2];
   assign edges      = fltPrev & ~iFLT_N;
   assign grant      = pending & (~pending + NUM_FLT'(1));
   assign pushEntry  = '{code: lowIdx(pending), state: iFSM_State, ts: 16'(tsCnt)};
   assign oRd_Data   = rdEntry;
   assign oLog_Count = 4'(cnt);
   fault_log_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
      .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear),
      .iPush(|pending), .iPushData(pushEntry), .iPop(iRd_Req),
      .oPopValid(oRd_Valid), .oPopData(rdEntry),
      .oFull(full), .oEmpty(empty), .oDrop(drop), .oCount(cnt)
   );
   always_ff @(posedge iClk or negedge iRst_n)
      if (!iRst_n) begin
         msSync        <= '0;
         tsCnt         <= '0;
         fltPrev       <= '1;
         pending       <= '0;
         oFlt_Sticky   <= '0;
         oFirst_Valid  <= 1'b0;
         oFirst_Code   <= '0;
         oOverflow     <= 1'b0;
         oFault_Any_N  <= 1'b1;
         oShutdown_Req <= 1'b0;
      end else begin
         msSync        <= {msSync[1:0], iClk_1ms};
         tsCnt         <= tsCnt + TS_W'(msTick);
         fltPrev       <= iFLT_N;
         oFault_Any_N  <= ~|oFlt_Sticky;
         oShutdown_Req <= |(oFlt_Sticky & SHDN_MASK);
         if (iClear) begin
            pending      <= '0;
            oFlt_Sticky  <= '0;
            oFirst_Valid <= 1'b0;
            oFirst_Code  <= '0;
            oOverflow    <= 1'b0;
         end else begin
            pending     <= (pending & ~grant) | edges;
            oFlt_Sticky <= oFlt_Sticky | edges;
            oOverflow   <= oOverflow | drop;
            if (!oFirst_Valid && |edges) begin
               oFirst_Valid <= 1'b1;
               oFirst_Code  <= lowIdx(edges);
            end
         end
      end
endmodule

// File: tb/tb_pwr_fault_log.sv
// tb_pwr_fault_log: randomized scoreboard bench against a queue-based model of the fault log
module tb_pwr_fault_log;
   import pwr_seq_pkg::*;
   localparam int NF = 9;
   localparam int TSW = 8;
   localparam logic [NF-1:0] MASK = 9'h180;
   logic iClk = 1'b0, iRst_n = 1'b1, iClk_1ms = 1'b0, iClear = 1'b0, iRd_Req = 1'b0;
   logic [NF-1:0] iFLT_N = '1;
   logic [3:0] iFSM_State = ST_IDLE;
   logic oRd_Valid, oOverflow, oFirst_Valid, oFault_Any_N, oShutdown_Req;
   logic [23:0] oRd_Data;
   logic [3:0] oLog_Count, oFirst_Code;
   logic [NF-1:0] oFlt_Sticky;
   pwr_fault_log #(.NUM_FLT(NF), .FIFO_DEPTH(8), .TS_W(TSW), .SHDN_MASK(MASK)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iClk_1ms(iClk_1ms), .iFLT_N(iFLT_N),
      .iFSM_State(iFSM_State), .iClear(iClear), .iRd_Req(iRd_Req),
      .oRd_Valid(oRd_Valid), .oRd_Data(oRd_Data), .oLog_Count(oLog_Count),
      .oOverflow(oOverflow), .oFlt_Sticky(oFlt_Sticky), .oFirst_Valid(oFirst_Valid),
      .oFirst_Code(oFirst_Code), .oFault_Any_N(oFault_Any_N), .oShutdown_Req(oShutdown_Req)
   );
   always #5 iClk = ~iClk;
   int total = 0, bad = 0, msCount = 0;
   bit mon = 0;
   logic [23:0] mq[$];
   logic [23:0] expRd[$];
   logic [NF-1:0] mPrev = '1, mPend = '0, mSticky = '0, mStickyQ = '0, mEdge;
   bit mFirstV = 0, mOvf = 0, mPopped;
   int mFirst = 0, mIdx;
   logic [3:0] states [9] = '{ST_IDLE, ST_STBY, ST_FAN, ST_DEV, ST_HOST, ST_S0, ST_DCOFF, ST_LEAK, ST_FAULT};
   function automatic int lowest(input logic [NF-1:0] v);
      for (int i = 0; i < NF; i++) if (v[i]) return i;
      return -1;
   endfunction
   // reference model: one step per clock edge, FIFO kept as a plain queue
   always @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         mq.delete(); expRd.delete();
         mPrev = '1; mPend = '0; mSticky = '0; mStickyQ = '0;
         mFirstV = 0; mFirst = 0; mOvf = 0;
      end else begin
         mEdge = mPrev & ~iFLT_N;
         mStickyQ = mSticky;
         if (iClear) begin
            mq.delete(); mPend = '0; mSticky = '0; mFirstV = 0; mFirst = 0; mOvf = 0;
         end else begin
            mPopped = iRd_Req && mq.size() > 0;
            if (mPopped) expRd.push_back(mq.pop_front());
            if (mPend != 0) begin
               mIdx = lowest(mPend);
               mPend[mIdx] = 1'b0;
               if (mq.size() < 8) mq.push_back({4'(mIdx), iFSM_State, 16'(msCount % (1 << TSW))});
               else mOvf = 1;
            end
            mPend |= mEdge;
            mSticky |= mEdge;
            if (!mFirstV && mEdge != 0) begin mFirstV = 1; mFirst = lowest(mEdge); end
         end
         mPrev = iFLT_N;
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge iClk) if (mon) begin
      if (oRd_Valid) begin
         if (expRd.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got %h expected no valid at %0t", oRd_Data, $time);
         end else chk("rd_data", oRd_Data, expRd.pop_front());
      end else if (expRd.size() != 0) begin
         total++; bad++;
         $display("FAIL rd_missing: got no valid expected %h at %0t", expRd[0], $time);
         expRd.delete();
      end
      chk("count", oLog_Count, mq.size());
      chk("overflow", oOverflow, mOvf);
      chk("sticky", oFlt_Sticky, mSticky);
      chk("first_valid", oFirst_Valid, mFirstV);
      chk("first_code", oFirst_Code, mFirst);
      chk("fault_any_n", oFault_Any_N, ~|mStickyQ);
      chk("shutdown", oShutdown_Req, |(mStickyQ & MASK));
   end
   task automatic drive(input logic [NF-1:0] f, input bit rd, input bit clr);
      @(negedge iClk);
      iFLT_N = f; iRd_Req = rd; iClear = clr;
   endtask
   task automatic idle(input int n);
      repeat (n) drive(iFLT_N, 0, 0);
   endtask
   task automatic ticks(input int n);
      idle(12);
      repeat (n) begin
         @(negedge iClk); iClk_1ms = 1'b1; msCount++;
         repeat (2) @(negedge iClk);
         iClk_1ms = 1'b0;
         @(negedge iClk);
      end
      idle(4);
   endtask
   task automatic doReset;
      @(negedge iClk);
      #2 iRst_n = 1'b0; iClk_1ms = 1'b0; iClear = 1'b0; iRd_Req = 1'b0; msCount = 0;
      repeat (2) @(negedge iClk);
      iRst_n = 1'b1;
   endtask
   initial begin
      logic [NF-1:0] f;
      #1 iRst_n = 1'b0; mon = 1;
      repeat (3) @(negedge iClk);
      iRst_n = 1'b1;
      ticks(3);
      drive(9'h1EF, 0, 0); idle(4); drive(9'h1EF, 1, 0); idle(3);
      drive(9'h1EF, 0, 1); idle(3);
      iFSM_State = ST_S0;
      drive(9'h16B, 0, 0); idle(4); drive(9'h16B, 1, 0); drive(9'h16B, 1, 0); idle(3);
      drive(9'h1FF, 0, 1); idle(2);
      for (int i = 0; i < NF; i++) drive(iFLT_N & ~(9'(1) << i), 0, 0);
      drive(iFLT_N | 9'h001, 0, 0); drive(iFLT_N & ~9'h001, 0, 0);
      idle(12);
      repeat (9) drive(iFLT_N, 1, 0);
      idle(3);
      drive(9'h1FF, 0, 1); idle(2);
      for (int i = 0; i < 8; i++) drive(iFLT_N & ~(9'(1) << i), 0, 0);
      idle(12);
      drive(iFLT_N & ~9'h100, 0, 0); drive(iFLT_N, 1, 0); idle(3);
      repeat (9) drive(iFLT_N, 1, 0);
      idle(3);
      drive(9'h1FF, 0, 1); idle(2);
      drive(9'h1DF, 0, 0); idle(4); drive(9'h1DF, 0, 1); idle(6);
      drive(9'h1FF, 0, 0); drive(9'h1DF, 0, 0); idle(4);
      drive(9'h1DF, 1, 0); idle(3);
      ticks(257 - (msCount % 256));
      drive(iFLT_N & ~9'h001, 0, 0); idle(4); drive(iFLT_N, 1, 0); idle(3);
      for (int n = 0; n < 1500; n++) begin
         if (n == 700) doReset;
         if ($urandom_range(0, 39) == 0) ticks($urandom_range(1, 3));
         f = iFLT_N;
         if ($urandom_range(0, 2) == 0) f[$urandom_range(0, 8)] ^= 1'b1;
         if ($urandom_range(0, 7) == 0) f[$urandom_range(0, 8)] ^= 1'b1;
         iFSM_State = states[$urandom_range(0, 8)];
         drive(f, $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0);
      end
      idle(12);
      repeat (10) drive(iFLT_N, 1, 0);
      idle(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
